// File: rtl/alu_param_core.sv
// alu_param_core: start/done ALU with parametrised width; single-cycle add/and/xor/sub,
// iterative shift-add multiply (one bit of B per cycle), err pulse on reserved opcodes.
module alu_param_core #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [2:0]         op,
    input  logic               start,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               err
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state_q;
    logic             done_q, busy_q, err_q;
    logic [RW-1:0]    result_q, acc_q, mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt_q;
    logic [RW-1:0]    ax, bx, alu_d, acc_d;
    logic             last_d;

    always_comb begin
        ax     = {{WIDTH{1'b0}}, A};
        bx     = {{WIDTH{1'b0}}, B};
        alu_d  = op == 3'b001 ? ax + bx :
                 op == 3'b010 ? ax & bx :
                 op == 3'b011 ? ax ^ bx :
                 op == 3'b101 ? ax - bx : '0;
        acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
        last_d = cnt_q == CW'(WIDTH - 1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (state_q == IDLE) begin
                if (start && op == 3'b100) begin
                    state_q  <= MUL;
                    busy_q   <= 1'b1;
                    cnt_q    <= '0;
                    acc_q    <= '0;
                    mcand_q  <= ax;
                    mplier_q <= B;
                end else if (start) begin
                    result_q <= alu_d;
                    done_q   <= 1'b1;
                    err_q    <= op[2] & op[1];
                end
            end else begin
                // multiplicand shifts left while multiplier shifts right, so bit 0 is always the current bit
                acc_q    <= acc_d;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 1'b1;
                if (last_d) begin
                    result_q <= acc_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            end
        end
    end

    assign done   = done_q;
    assign busy   = busy_q;
    assign err    = err_q;
    assign result = result_q;
endmodule

// File: tb/tb_alu_param_core.sv
// tb_alu_param_core: directed checks of the ALU at WIDTH=8 and WIDTH=16.
module tb_alu_param_core;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [2:0]  op = '0;
    logic        start = 1'b0, start16 = 1'b0;
    logic        done, busy, err, done16, busy16, err16;
    logic [15:0] result;
    logic [31:0] result16;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    alu_param_core #(.WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .A(a8), .B(b8), .op(op), .start(start),
        .done(done), .result(result), .busy(busy), .err(err)
    );

    alu_param_core #(.WIDTH(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .A(a16), .B(b16), .op(op), .start(start16),
        .done(done16), .result(result16), .busy(busy16), .err(err16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b1; op = 3'b100; a8 = 8'h05; b8 = 8'h07;
        tick();
        tick();
        checks++;
        if ({done, busy, err, result} !== {3'b000, 16'h0000}) begin
            failures++;
            $display("FAIL reset_hold: done/busy/err/result=%b%b%b %h required 000 0000", done, busy, err, result);
        end
        start = 1'b0;
        reset_n = 1'b1;
        tick();
        checks++;
        if ({done, busy, err, result} !== {3'b000, 16'h0000}) begin
            failures++;
            $display("FAIL reset_release: done/busy/err/result=%b%b%b %h required 000 0000", done, busy, err, result);
        end
    endtask

    task automatic test_single_ops();
        logic [2:0]  ops [4] = '{3'b001, 3'b010, 3'b011, 3'b101};
        logic [7:0]  av  [4] = '{8'hFF, 8'hF0, 8'hF0, 8'h03};
        logic [7:0]  bv  [4] = '{8'h01, 8'h3C, 8'h3C, 8'h05};
        logic [15:0] exp [4] = '{16'h0100, 16'h0030, 16'h00CC, 16'hFFFE};
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op = ops[i]; a8 = av[i]; b8 = bv[i];
            tick();
            checks++;
            if ({done, busy, err, result} !== {3'b100, exp[i]}) begin
                failures++;
                $display("FAIL single_op%0d: done/busy/err/result=%b%b%b %h required 100 %h", i, done, busy, err, result, exp[i]);
            end
        end
        start = 1'b0;
        tick();
        checks++;
        if ({done, err, result} !== {2'b00, 16'hFFFE}) begin
            failures++;
            $display("FAIL single_idle: done/err/result=%b%b %h required 00 fffe", done, err, result);
        end
    endtask

    task automatic test_mul_busy();
        int ndone = 0;
        op = 3'b100; a8 = 8'hFF; b8 = 8'hFF; start = 1'b1;
        tick();
        checks++;
        if ({done, busy} !== 2'b01) begin
            failures++;
            $display("FAIL mul_capture: done/busy=%b%b required 01", done, busy);
        end
        op = 3'b001;
        for (int k = 1; k < 8; k++) begin
            start = k[0];
            a8 = 8'(k); b8 = 8'(k);
            tick();
            ndone += int'(done);
            checks++;
            if ({done, busy, result} !== {2'b01, 16'hFFFE}) begin
                failures++;
                $display("FAIL mul_busy%0d: done/busy/result=%b%b %h required 01 fffe", k, done, busy, result);
            end
        end
        start = 1'b1; a8 = 8'h01; b8 = 8'h01;
        tick();
        ndone += int'(done);
        checks++;
        if ({done, busy, err, result} !== {3'b100, 16'hFE01}) begin
            failures++;
            $display("FAIL mul_done: done/busy/err/result=%b%b%b %h required 100 fe01", done, busy, err, result);
        end
        checks++;
        if (ndone !== 1) begin
            failures++;
            $display("FAIL mul_done_count: got %0d required 1", ndone);
        end
        tick();
        start = 1'b0;
        checks++;
        if ({done, busy, result} !== {2'b10, 16'h0002}) begin
            failures++;
            $display("FAIL after_mul_capture: done/busy/result=%b%b %h required 10 0002", done, busy, result);
        end
        tick();
    endtask

    task automatic test_reserved();
        op = 3'b110; a8 = 8'h12; b8 = 8'h34; start = 1'b1;
        tick();
        checks++;
        if ({done, err, result} !== {2'b11, 16'h0000}) begin
            failures++;
            $display("FAIL reserved: done/err/result=%b%b %h required 11 0000", done, err, result);
        end
        op = 3'b001; a8 = 8'h01; b8 = 8'h01;
        tick();
        start = 1'b0;
        checks++;
        if ({done, err, result} !== {2'b10, 16'h0002}) begin
            failures++;
            $display("FAIL reserved_next: done/err/result=%b%b %h required 10 0002", done, err, result);
        end
        tick();
        checks++;
        if ({done, err} !== 2'b00) begin
            failures++;
            $display("FAIL reserved_idle: done/err=%b%b required 00", done, err);
        end
    endtask

    task automatic test_reset_mid_mul();
        op = 3'b100; a8 = 8'h02; b8 = 8'h03; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        checks++;
        if ({done, busy, result} !== {2'b00, 16'h0000}) begin
            failures++;
            $display("FAIL reset_mid: done/busy/result=%b%b %h required 00 0000", done, busy, result);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if ({done, busy} !== 2'b00) begin
                failures++;
                $display("FAIL reset_mid_quiet%0d: done/busy=%b%b required 00", k, done, busy);
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 8; k++) begin
            tick();
            checks++;
            if ({done, busy} !== 2'b01) begin
                failures++;
                $display("FAIL reissue_busy%0d: done/busy=%b%b required 01", k, done, busy);
            end
        end
        tick();
        checks++;
        if ({done, busy, result} !== {2'b10, 16'h0006}) begin
            failures++;
            $display("FAIL reissue_done: done/busy/result=%b%b %h required 10 0006", done, busy, result);
        end
    endtask

    task automatic test_width16();
        op = 3'b100; a16 = 16'hFFFF; b16 = 16'h0002; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        for (int k = 1; k < 16; k++) begin
            tick();
            checks++;
            if ({done16, busy16} !== 2'b01) begin
                failures++;
                $display("FAIL w16_busy%0d: done/busy=%b%b required 01", k, done16, busy16);
            end
        end
        tick();
        checks++;
        if ({done16, busy16, result16} !== {2'b10, 32'h0001FFFE}) begin
            failures++;
            $display("FAIL w16_mul: done/busy/result=%b%b %h required 10 0001fffe", done16, busy16, result16);
        end
        op = 3'b001; a16 = 16'hFFFF; b16 = 16'h0001; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        checks++;
        if ({done16, err16, result16} !== {2'b10, 32'h00010000}) begin
            failures++;
            $display("FAIL w16_add: done/err/result=%b%b %h required 10 00010000", done16, err16, result16);
        end
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_mul_busy();
        test_reserved();
        test_reset_mid_mul();
        test_width16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_param_core.md
Name: alu_param_core

Overview:
- Parametrised successor to the 8-bit start/done ALU. Operand width is configurable.
- Adds a subtract op, a busy output and an error flag for reserved opcodes.
- Multiply is iterative (shift-add, one bit per cycle); all other ops complete in one cycle.
- Sits directly behind the test interface as the DUT; its handshake matches the existing start/done protocol.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32); result width is 2*WIDTH.

Ports:
- clk  input  1  single clock; all logic updates on its rising edge
- reset_n  input  1  synchronous active-low reset
- A  input  WIDTH  operand A, unsigned
- B  input  WIDTH  operand B, unsigned
- op  input  3  opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 101 sub, 110/111 reserved
- start  input  1  request; sampled each rising edge
- done  output  1  one-cycle pulse; result valid
- result  output  2*WIDTH  result of the last completed op
- busy  output  1  multiply in progress; new requests are ignored
- err  output  1  one-cycle pulse aligned with done; reserved opcode

Behaviour:
- Reset: on a rising edge with reset_n=0:
  - state goes to IDLE
  - done=0, busy=0, err=0, result=0
  - multiplier accumulator and counter are cleared
  - this applies in any state; a reset during MUL aborts the op with no done
- States: IDLE, MUL.
- Capture: on a rising edge with start=1 and busy=0, the block latches A, B and op. Call this edge c.
- Single-cycle ops (no_op, add, and, xor, sub, reserved):
  - result is registered and done=1 at edge c, so done is visible the cycle after start is sampled
  - state stays IDLE; busy stays 0
  - add: zero-extended A+B, carry in bit WIDTH
  - and, xor: zero-extended bitwise result
  - sub: A-B computed in 2*WIDTH bits, modulo 2^(2*WIDTH) (example: 3-5 gives all-ones except LSB, 0xFFFE at WIDTH=8)
  - no_op: result=0, done=1
  - reserved (110/111): result=0, done=1, err=1
- mul:
  - at edge c, state goes to MUL, busy=1, counter=0, accumulator=0
  - each edge in MUL performs one shift-add iteration on the next bit of B (LSB first) and increments the counter
  - at edge c+WIDTH (the final iteration): result = unsigned A*B in full 2*WIDTH bits, done=1, busy=0, state goes to IDLE
- done and err:
  - both are high for exactly one cycle per accepted op
  - they are deasserted on every edge that does not complete an op
- result holds its value between completions; it changes only when done is asserted or on reset.
- start while busy=1: ignored, with no queueing, no error and no effect on the running op.
- start=1 on the edge where MUL completes is not captured, because busy is still 1 at that edge. It is captured on the next edge if start is still high.
- start held high in IDLE: every edge is a new capture, so back-to-back single-cycle ops give done on consecutive cycles.
- Operand changes after capture have no effect on the running op.
- Latency summary:
  - single-cycle ops: done 1 cycle after the start-sampling edge
  - mul: done WIDTH cycles after capture edge c
  - throughput: one single-cycle op per cycle; one mul per WIDTH+1 cycles at best

Test Plan:
- Reset, WIDTH=8: hold reset_n=0 for 2 cycles with start=1, op=100 -> done=0, busy=0, err=0, result=0x0000; no capture occurs.
- Single-cycle ops, WIDTH=8:
  - add 0xFF+0x01 -> done next cycle, result 0x0100
  - and 0xF0&0x3C -> 0x0030
  - xor 0xF0^0x3C -> 0x00CC
  - sub 0x03-0x05 -> 0xFFFE
  - issued back-to-back -> done on 4 consecutive cycles, err=0
- Multiply, WIDTH=8: mul 0xFF*0xFF -> busy=1 for 8 cycles, done at capture+8, result 0xFE01. Start pulses with add during busy are ignored: exactly one done, and result is unchanged before completion.
- Reserved opcode: op=110, A=0x12, B=0x34 -> done=1 and err=1 for one cycle, result 0x0000. The next op is add 1+1 -> err=0, result 0x0002.
- Reset mid-op: mul 0x02*0x03, reset_n=0 at capture+3 -> busy=0, result=0, no done. Reissue the same mul -> done at capture+8, result 0x0006.
- Width generalisation, WIDTH=16: mul 0xFFFF*0x0002 -> done at capture+16, result 0x0001FFFE. add 0xFFFF+0x0001 -> 0x00010000.
